// File: rtl/nibble_table_streamer.sv
// nibble_table_streamer
// Loadable table of EW-bit elements organised as [CH][ROWS][COLS]. On start
// it streams every element over a valid/ready interface. Elements can be sent
// raw, inverted, or NAND-masked, in ascending or descending order. After the
// final element it reports the XOR checksum of everything it emitted.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   wr_en/wr_ch/wr_row/wr_col  random-access write port, usable in any state
//   wr_data                    element written at [wr_ch][wr_row][wr_col]
//   start, mode, mask          begin a scan; mode and mask captured with it
//   abort                      terminate a scan without a checksum
//   out_valid/out_ready        output handshake
//   out_data/out_idx/out_last  transformed element, flat index, final flag
//   busy                       high while scanning
//   sum_valid/sum              one-cycle checksum report after the last element
module nibble_table_streamer #(
  parameter int CH   = 4,
  parameter int ROWS = 2,
  parameter int COLS = 3,
  parameter int EW   = 4,
  localparam int N   = CH * ROWS * COLS,
  localparam int IW  = (N    > 1) ? $clog2(N)    : 1,
  localparam int CW  = (CH   > 1) ? $clog2(CH)   : 1,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int LW  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_ch,
  input  logic [RW-1:0] wr_row,
  input  logic [LW-1:0] wr_col,
  input  logic [EW-1:0] wr_data,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [EW-1:0] mask,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          busy,
  output logic          sum_valid,
  output logic [EW-1:0] sum
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t        state;
  logic [EW-1:0] mem [N];
  logic [1:0]    mode_q;
  logic [EW-1:0] mask_q;
  logic [EW-1:0] acc;

  logic          wr_inrange;
  logic [IW-1:0] wr_addr;
  logic [IW-1:0] first_idx;
  logic [IW-1:0] next_idx;
  logic [IW-1:0] final_idx;

  // Element transform, applied when an element is loaded into the output register.
  function automatic logic [EW-1:0] xform(input logic [EW-1:0] elem,
                                          input logic [1:0]    m,
                                          input logic [EW-1:0] mk);
    case (m)
      2'd1:    xform = ~elem;
      2'd2:    xform = ~(elem & mk);
      default: xform = elem;
    endcase
  endfunction

  // Write address decode: indices outside the table dimensions are dropped
  // instead of aliasing onto another element.
  assign wr_inrange = (int'(wr_ch) < CH) && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign wr_addr    = IW'(int'(wr_ch) * ROWS * COLS + int'(wr_row) * COLS + int'(wr_col));

  // Scan order: mode 3 runs descending, every other mode ascending. first_idx
  // uses the live mode because it is consumed on the same edge that captures it.
  assign first_idx = (mode == 2'd3) ? LAST_IDX : '0;
  assign next_idx  = (mode_q == 2'd3) ? (out_idx - 1'b1) : (out_idx + 1'b1);
  assign final_idx = (mode_q == 2'd3) ? '0 : LAST_IDX;

  // Table storage. The output register in the block below reads the pre-edge
  // contents, so a same-edge write never leaks into the element being loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && wr_inrange) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Scan controller with registered outputs. Abort takes priority over the
  // handshake. The final handshake folds the last element into the checksum
  // and publishes it for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 2'd0;
      mask_q    <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      sum_valid <= 1'b0;
      sum       <= '0;
    end else begin
      sum_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state     <= SCAN;
            mode_q    <= mode;
            mask_q    <= mask;
            acc       <= '0;
            out_idx   <= first_idx;
            out_data  <= xform(mem[first_idx], mode, mask);
            out_last  <= (N == 1);
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SCAN: begin
          if (abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_last  <= 1'b0;
          end else if (out_valid && out_ready) begin
            acc <= acc ^ out_data;
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_last  <= 1'b0;
              sum       <= acc ^ out_data;
              sum_valid <= 1'b1;
            end else begin
              out_idx  <= next_idx;
              out_data <= xform(mem[next_idx], mode_q, mask_q);
              out_last <= (next_idx == final_idx);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_table_streamer.sv
// tb_nibble_table_streamer
// Directed bench for nibble_table_streamer with the default 4x2x3 table of
// 4-bit elements. Full scans are described by a record table; stalls, writes
// during a scan, abort and mid-scan reset are hand-written sequences.
module tb_nibble_table_streamer;

  localparam int N = 24;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [0:0] wr_row;
  logic [1:0] wr_col;
  logic [3:0] wr_data;
  logic       start;
  logic [1:0] mode;
  logic [3:0] mask;
  logic       abort;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [4:0] out_idx;
  logic       out_last;
  logic       busy;
  logic       sum_valid;
  logic [3:0] sum;

  int compared;
  int mismatched;

  logic [3:0] model [N];
  logic [3:0] capData [N];
  int         capFirstIdx;
  logic [3:0] capFirstData;
  logic [3:0] capSum;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] mask;
    int         chkIdx;
    logic [3:0] chkData;
    int         firstIdx;
    logic [3:0] firstData;
    logic [3:0] expSum;
  } vec_t;

  vec_t vecs [4];

  nibble_table_streamer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .start     (start),
    .mode      (mode),
    .mask      (mask),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .sum_valid (sum_valid),
    .sum       (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] xf(input logic [3:0] e, input logic [1:0] m, input logic [3:0] mk);
    if (m == 2'd1)      return ~e;
    else if (m == 2'd2) return ~(e & mk);
    else                return e;
  endfunction

  task automatic writeElem(input int ch, input int row, input int col, input logic [3:0] d);
    wr_en   = 1'b1;
    wr_ch   = 2'(ch);
    wr_row  = 1'(row);
    wr_col  = 2'(col);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, out_valid, 0);
    checkOutput({tag, "_data"},  out_data,  0);
    checkOutput({tag, "_idx"},   out_idx,   0);
    checkOutput({tag, "_last"},  out_last,  0);
    checkOutput({tag, "_busy"},  busy,      0);
    checkOutput({tag, "_sumv"},  sum_valid, 0);
    checkOutput({tag, "_sum"},   sum,       0);
  endtask

  // Full scan with out_ready held high: every element is checked against the
  // bench table model, then the checksum pulse is checked.
  task automatic runScan(input logic [1:0] m, input logic [3:0] mk);
    int         ei;
    logic [3:0] ed;
    logic [3:0] expSum;
    expSum    = 4'h0;
    mode      = m;
    mask      = mk;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("scan_busy", busy, 1);
    for (int k = 0; k < N; k++) begin
      ei = (m == 2'd3) ? (N - 1 - k) : k;
      ed = xf(model[ei], m, mk);
      if (!out_valid) begin
        checkOutput("scan_valid", out_valid, 1);
        break;
      end
      if (k == 0) begin
        capFirstIdx  = int'(out_idx);
        capFirstData = out_data;
      end
      capData[ei] = out_data;
      checkOutput("scan_idx",  out_idx,  ei);
      checkOutput("scan_data", out_data, ed);
      checkOutput("scan_last", out_last, (k == N - 1));
      expSum ^= ed;
      tick();
    end
    capSum = sum;
    checkOutput("end_valid", out_valid, 0);
    checkOutput("end_busy",  busy,      0);
    checkOutput("end_sumv",  sum_valid, 1);
    checkOutput("end_sum",   sum,       expSum);
    tick();
    checkOutput("sumv_pulse", sum_valid, 0);
  endtask

  // Run one record of the scan table and compare its hand-computed values.
  task automatic applyStimulus(input vec_t v);
    runScan(v.mode, v.mask);
    checkOutput("vec_chk_data",   capData[v.chkIdx], v.chkData);
    checkOutput("vec_first_idx",  capFirstIdx,       v.firstIdx);
    checkOutput("vec_first_data", capFirstData,      v.firstData);
    checkOutput("vec_sum",        capSum,            v.expSum);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    wr_en      = 1'b0;
    wr_ch      = '0;
    wr_row     = '0;
    wr_col     = '0;
    wr_data    = '0;
    start      = 1'b0;
    mode       = 2'd0;
    mask       = 4'h0;
    abort      = 1'b0;
    out_ready  = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 4'h0;

    vecs[0] = '{mode: 2'd0, mask: 4'h0, chkIdx: 8,  chkData: 4'hA, firstIdx: 0,  firstData: 4'h0, expSum: 4'hF};
    vecs[1] = '{mode: 2'd1, mask: 4'h0, chkIdx: 8,  chkData: 4'h5, firstIdx: 0,  firstData: 4'hF, expSum: 4'hF};
    vecs[2] = '{mode: 2'd2, mask: 4'hC, chkIdx: 8,  chkData: 4'h7, firstIdx: 0,  firstData: 4'hF, expSum: 4'hC};
    vecs[3] = '{mode: 2'd3, mask: 4'h0, chkIdx: 23, chkData: 4'h5, firstIdx: 23, firstData: 4'h5, expSum: 4'hF};

    #2;
    checkAllZero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    runScan(2'd0, 4'h0);

    writeElem(1, 0, 2, 4'hA);
    model[8] = 4'hA;
    writeElem(3, 1, 2, 4'h5);
    model[23] = 4'h5;
    writeElem(0, 0, 3, 4'h9);
    tick();

    for (int v = 0; v < 4; v++) applyStimulus(vecs[v]);

    // Stall with out_ready 1,0,0,1; write the held index and pulse start
    // (with descending mode) while stalled.
    mode      = 2'd0;
    mask      = 4'h0;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("stall_idx0", out_idx, 0);
    tick();
    checkOutput("stall_idx1", out_idx, 1);
    out_ready = 1'b0;
    wr_en     = 1'b1;
    wr_ch     = 2'd0;
    wr_row    = 1'd0;
    wr_col    = 2'd1;
    wr_data   = 4'h3;
    tick();
    wr_en    = 1'b0;
    model[1] = 4'h3;
    checkOutput("stall_hold_idx",  out_idx,   1);
    checkOutput("stall_hold_data", out_data,  0);
    checkOutput("stall_hold_vld",  out_valid, 1);
    mode  = 2'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("stall2_idx",  out_idx,  1);
    checkOutput("stall2_data", out_data, 0);
    checkOutput("stall2_busy", busy,     1);
    out_ready = 1'b1;
    tick();
    checkOutput("resume_idx", out_idx, 2);
    for (int c = 0; c < N + 2; c++) begin
      if (!out_valid) break;
      tick();
    end
    checkOutput("stall_sumv", sum_valid, 1);
    checkOutput("stall_sum",  sum,       4'hF);
    tick();

    // Abort while element 5 is held: no checksum report, sum keeps 4'hF.
    mode      = 2'd0;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    checkOutput("abort_at_idx", out_idx, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_valid", out_valid, 0);
    checkOutput("abort_busy",  busy,      0);
    checkOutput("abort_last",  out_last,  0);
    checkOutput("abort_sumv",  sum_valid, 0);
    checkOutput("abort_sum",   sum,       4'hF);
    tick();
    checkOutput("abort_sumv2", sum_valid, 0);

    // Asynchronous reset mid-scan, then a scan of the cleared table.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++) model[i] = 4'h0;
    runScan(2'd0, 4'h0);
    checkOutput("post_rst_sum", capSum, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nibble_table_streamer.md
Name: nibble_table_streamer

Overview:
- Parametrised table of EW-bit elements organised as [CH][ROWS][COLS], written through a random-access port.
- On command, streams every element out over a valid/ready interface, optionally transformed, with an XOR checksum at the end.
- Generalises the fixed constant nibble-array driver into a loadable, sized, sequential block with transform modes.
- Sits between configuration logic (writer) and any downstream element consumer.

Parameters:
- CH, 4, channel count (outermost dimension)
- ROWS, 2, rows per channel
- COLS, 3, columns per row (innermost dimension)
- EW, 4, element width in bits
- Derived: N = CH*ROWS*COLS; IW = max(1, clog2(N)); CW/RW/LW = max(1, clog2(CH/ROWS/COLS))

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe
- wr_ch  in  CW  write channel index
- wr_row  in  RW  write row index
- wr_col  in  LW  write column index
- wr_data  in  EW  write data
- start  in  1  begin scan (pulse, sampled in IDLE only)
- mode  in  2  transform/order, sampled with start
- mask  in  EW  NAND mask, sampled with start
- abort  in  1  terminate scan
- out_valid  out  1  element available
- out_ready  in  1  consumer accepts
- out_data  out  EW  transformed element
- out_idx  out  IW  flat index ch*ROWS*COLS + row*COLS + col
- out_last  out  1  high with final element
- busy  out  1  high in SCAN
- sum_valid  out  1  one-cycle pulse after final handshake
- sum  out  EW  XOR of all emitted out_data

Behaviour:
- Reset (async, rst_n=0): all table elements 0, state IDLE; out_valid, out_data, out_idx, out_last, busy, sum_valid and sum all 0. Captured mode and mask cleared.
- Writes:
  - wr_en=1 writes wr_data to [wr_ch][wr_row][wr_col] at the clock edge, in any state.
  - Out-of-range indices (>= CH/ROWS/COLS) are ignored.
- States: IDLE, SCAN.
- IDLE to SCAN when start=1 (and abort=0). That edge:
  - captures mode and mask;
  - loads the first element into the output register;
  - sets out_valid=1 and busy=1, clears the running checksum.
  - Latency start to out_valid: 1 cycle.
- Order:
  - mode 0/1/2: ascending flat index, 0 .. N-1.
  - mode 3: descending, N-1 .. 0.
- Transform applied at output-register load:
  - mode 0: raw.
  - mode 1: bitwise NOT.
  - mode 2: ~(elem & mask).
  - mode 3: raw.
- Handshake:
  - The output register holds stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready, the checksum is XOR-accumulated with out_data and the next element loads at the same edge, so back-to-back transfers run at one element per cycle.
- out_last=1 exactly when the held element is the final one in scan order.
- Final handshake (out_last && out_ready):
  - next state IDLE; out_valid=0, busy=0, out_last=0;
  - sum = accumulated XOR including the last element;
  - sum_valid=1 for exactly one cycle.
- Read/write interaction: the output register samples the table before a same-edge write (read-before-write). Writes to an index already held or already emitted do not alter out_data or sum.
- start while in SCAN is ignored.
- abort=1 in SCAN (priority over the handshake): next edge goes to IDLE, out_valid=0, busy=0, out_last=0, no sum_valid pulse, sum unchanged. abort in IDLE has no effect.
- N=1: first element carries out_last=1.
- Index counters wrap-free: the counter never exceeds N-1 or goes below 0.
- rst_n asserted mid-scan: immediate return to the reset values above; table contents are lost.

Test Plan:
- Reset then scan, mode 0 with out_ready=1 → 24 elements, all out_data=0, out_idx 0..23, out_last only at idx 23; sum_valid pulse with sum=0.
- Write [1][0][2]=4'hA and [3][1][2]=4'h5, scan mode 0 → idx 8 gives 4'hA, idx 23 gives 4'h5 with out_last; sum=4'hF.
- Same table, mode 1 → idx 0 gives 4'hF, idx 8 gives 4'h5. Mode 2 with mask=4'hC → idx 8 gives ~(4'hA&4'hC)=4'h7.
- Mode 3 → first transfer idx 23 with data 4'h5, last transfer idx 0 with out_last=1.
- out_ready toggles 1,0,0,1 → out_data/out_idx stay stable during stalls. A same-cycle write to the held index does not change out_data. start pulsed mid-scan is ignored.
- abort at idx 5 → out_valid=0 and busy=0 next cycle, no sum_valid. rst_n pulsed low mid-scan → all outputs 0 asynchronously and a subsequent scan returns all-zero data.
